// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package ifq_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ifq_entry_t;

    // $clog2 returns 0 for 1; a zero-width bus is illegal, so clamp to 1.
    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the fetch queue: FETCH_N masked write ports, ISSUE_N
// combinational read ports. The array is deliberately left unreset.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_N = 2,
    parameter int ISSUE_N = 2,
    parameter int PTR_W   = clog2_safe(DEPTH)
) (
    input  logic                              clk,
    input  logic [FETCH_N-1:0]                wr_en,
    input  logic [FETCH_N-1:0][PTR_W-1:0]     wr_idx,
    input  ifq_entry_t [FETCH_N-1:0]          wr_data,
    input  logic [ISSUE_N-1:0][PTR_W-1:0]     rd_idx,
    output ifq_entry_t [ISSUE_N-1:0]          rd_data
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_N; k++) begin
            if (wr_en[k]) begin
                mem[wr_idx[k]] <= wr_data[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_N; i++) begin
            rd_data[i] = mem[rd_idx[i]];
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the instruction SRAM and multi-issue decode.
// Optional macro IFQ_STATS_EN adds full/empty cycle counters.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int FETCH_N = 2,
    parameter int ISSUE_N = 2,
    parameter int DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           fetch_valid,
    output logic                           fetch_ready,
    input  logic [31:0]                    fetch_pc,
    input  logic [32*FETCH_N-1:0]          fetch_rdata,
    output logic [ISSUE_N-1:0]             issue_valid,
    output logic [32*ISSUE_N-1:0]          issue_inst,
    output logic [32*ISSUE_N-1:0]          issue_pc,
    input  logic [$clog2(ISSUE_N+1)-1:0]   issue_take
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]                    stat_full_cyc,
    output logic [31:0]                    stat_empty_cyc
`endif
);

    localparam int PTR_W = clog2_safe(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = clog2_safe(FETCH_N);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] eff_take;
    logic [OFF_W-1:0] off;
    logic             accept;
    logic             unused_pc_lsb;

    logic [FETCH_N-1:0]            wr_en;
    logic [FETCH_N-1:0][PTR_W-1:0] wr_idx;
    logic [FETCH_N-1:0][OFF_W-1:0] src_word;
    ifq_entry_t [FETCH_N-1:0]      wr_data;
    logic [ISSUE_N-1:0][PTR_W-1:0] rd_idx;
    ifq_entry_t [ISSUE_N-1:0]      rd_data;

    assign unused_pc_lsb = ^fetch_pc[1:0];

    generate
        if (FETCH_N == 1) begin : g_off_single
            assign off = '0;
        end else begin : g_off_multi
            assign off = fetch_pc[OFF_W+1:2];
        end
    endgenerate

    // Ready looks only at registered occupancy, so a full queue needs one
    // cycle after a dequeue before it takes another beat.
    assign fetch_ready = (count <= CNT_W'(DEPTH - FETCH_N));
    assign accept      = fetch_valid & fetch_ready & ~flush;
    assign n_in        = CNT_W'(FETCH_N) - CNT_W'(off);

    always_comb begin
        eff_take = CNT_W'(issue_take);
        if (eff_take > count) begin
            eff_take = count;
        end
        if (eff_take > CNT_W'(ISSUE_N)) begin
            eff_take = CNT_W'(ISSUE_N);
        end
    end

    assign count_next = count + (accept ? n_in : '0) - eff_take;

    always_comb begin
        wr_en    = '0;
        wr_idx   = '0;
        src_word = '0;
        wr_data  = '0;
        for (int k = 0; k < FETCH_N; k++) begin
            src_word[k]     = off + OFF_W'(k);
            wr_en[k]        = accept && (CNT_W'(k) < n_in);
            wr_idx[k]       = wr_ptr + PTR_W'(k);
            wr_data[k].inst = fetch_rdata[32*src_word[k] +: 32];
            if (FETCH_N == 1) begin
                wr_data[k].pc = fetch_pc;
            end else begin
                wr_data[k].pc = {fetch_pc[31:OFF_W+2], src_word[k], 2'b00};
            end
        end
    end

    ifq_storage #(
        .DEPTH   (DEPTH),
        .FETCH_N (FETCH_N),
        .ISSUE_N (ISSUE_N),
        .PTR_W   (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        rd_idx      = '0;
        issue_valid = '0;
        issue_inst  = '0;
        issue_pc    = '0;
        for (int i = 0; i < ISSUE_N; i++) begin
            rd_idx[i]      = rd_ptr + PTR_W'(i);
            issue_valid[i] = (count > CNT_W'(i));
            if (issue_valid[i]) begin
                issue_inst[32*i +: 32] = rd_data[i].inst;
                issue_pc[32*i +: 32]   = rd_data[i].pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr + PTR_W'(eff_take);
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(n_in);
            end
        end
    end

`ifdef IFQ_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cyc  <= '0;
            stat_empty_cyc <= '0;
        end else begin
            if (!fetch_ready && (stat_full_cyc != 32'hFFFF_FFFF)) begin
                stat_full_cyc <= stat_full_cyc + 32'd1;
            end
            if ((count == '0) && (stat_empty_cyc != 32'hFFFF_FFFF)) begin
                stat_empty_cyc <= stat_empty_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_inst_fetch_queue;

    localparam int FETCH_N = 2;
    localparam int ISSUE_N = 2;
    localparam int DEPTH   = 8;
    localparam int TAKE_W  = $clog2(ISSUE_N + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   fetch_valid = 1'b0;
    logic                   fetch_ready;
    logic [31:0]            fetch_pc = '0;
    logic [32*FETCH_N-1:0]  fetch_rdata = '0;
    logic [ISSUE_N-1:0]     issue_valid;
    logic [32*ISSUE_N-1:0]  issue_inst;
    logic [32*ISSUE_N-1:0]  issue_pc;
    logic [TAKE_W-1:0]      issue_take = '0;
`ifdef IFQ_STATS_EN
    logic [31:0]            stat_full_cyc;
    logic [31:0]            stat_empty_cyc;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .FETCH_N (FETCH_N),
        .ISSUE_N (ISSUE_N),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_rdata (fetch_rdata),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .issue_pc    (issue_pc),
        .issue_take  (issue_take)
`ifdef IFQ_STATS_EN
        ,
        .stat_full_cyc  (stat_full_cyc),
        .stat_empty_cyc (stat_empty_cyc)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_full  = '0;
    logic [31:0] m_empty = '0;
    int          tests = 0;
    int          fails = 0;
    bit          check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {inst, pc}, updated on each rising edge.
    always @(posedge clk) begin
        int sz;
        int take;
        int off;
        bit rdy;
        sz  = mq.size();
        rdy = (DEPTH - sz) >= FETCH_N;
        if (rst) begin
            m_full  = '0;
            m_empty = '0;
        end else begin
            if (!rdy && m_full != 32'hFFFF_FFFF) m_full = m_full + 1;
            if (sz == 0 && m_empty != 32'hFFFF_FFFF) m_empty = m_empty + 1;
        end
        if (rst || flush) begin
            mq.delete();
        end else begin
            take = int'(issue_take);
            if (take > sz) take = sz;
            if (take > ISSUE_N) take = ISSUE_N;
            repeat (take) void'(mq.pop_front());
            if (fetch_valid && rdy) begin
                off = int'((fetch_pc >> 2) % FETCH_N);
                for (int k = off; k < FETCH_N; k++) begin
                    mq.push_back('{fetch_rdata[32*k +: 32],
                                   (fetch_pc & ~32'(FETCH_N*4 - 1)) + 32'(4*k)});
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int sz;
        if (check_en) begin
            sz = mq.size();
            chk("fetch_ready", 32'(fetch_ready), 32'((DEPTH - sz) >= FETCH_N));
            for (int i = 0; i < ISSUE_N; i++) begin
                chk("issue_valid", 32'(issue_valid[i]), 32'(i < sz));
                chk("issue_inst", issue_inst[32*i +: 32], (i < sz) ? mq[i].inst : 32'h0);
                chk("issue_pc", issue_pc[32*i +: 32], (i < sz) ? mq[i].pc : 32'h0);
            end
`ifdef IFQ_STATS_EN
            chk("stat_full_cyc", stat_full_cyc, m_full);
            chk("stat_empty_cyc", stat_empty_cyc, m_empty);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        for (int k = 0; k < FETCH_N; k++) begin
            fetch_rdata[32*k +: 32] = (pc & ~32'(FETCH_N*4 - 1)) + 32'(4*k);
        end
    endtask

    task automatic do_flush();
        fetch_valid = 1'b0;
        issue_take  = '0;
        flush       = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        cyc();
        check_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_valid", 32'(issue_valid), 32'h0);
        chk("reset_ready", 32'(fetch_ready), 32'h1);

        // Aligned beat
        fetch_valid = 1'b1;
        fetch_pc    = 32'h1000;
        fetch_rdata = {32'h2222, 32'h1111};
        cyc();
        fetch_valid = 1'b0;
        chk("t1_valid", 32'(issue_valid), 32'h3);
        chk("t1_inst0", issue_inst[31:0], 32'h1111);
        chk("t1_pc0", issue_pc[31:0], 32'h1000);
        chk("t1_inst1", issue_inst[63:32], 32'h2222);
        chk("t1_pc1", issue_pc[63:32], 32'h1004);
        do_flush();

        // Unaligned beat
        fetch_valid = 1'b1;
        fetch_pc    = 32'h1004;
        fetch_rdata = {32'hBBBB, 32'hAAAA};
        cyc();
        fetch_valid = 1'b0;
        chk("t2_model_cnt", 32'(mq.size()), 32'd1);
        chk("t2_valid", 32'(issue_valid), 32'h1);
        chk("t2_inst0", issue_inst[31:0], 32'hBBBB);
        chk("t2_pc0", issue_pc[31:0], 32'h1004);
        do_flush();

        // Fill to full, refused beat, then drain one at a time
        for (int i = 0; i < 4; i++) begin
            beat(32'h2000 + 32'(8*i));
            cyc();
        end
        chk("t3_full_ready", 32'(fetch_ready), 32'h0);
        chk("t3_model_cnt", 32'(mq.size()), 32'd8);
        beat(32'h2020);
        cyc();
        fetch_valid = 1'b0;
        chk("t3_no_ovf_pc0", issue_pc[31:0], 32'h2000);
        chk("t3_no_ovf_cnt", 32'(mq.size()), 32'd8);
        issue_take = 1;
        cyc();
        issue_take = 0;
        chk("t3_cnt7_ready", 32'(fetch_ready), 32'h0);
        chk("t3_cnt7_pc0", issue_pc[31:0], 32'h2004);
        issue_take = 1;
        cyc();
        issue_take = 0;
        chk("t3_cnt6_ready", 32'(fetch_ready), 32'h1);
        chk("t3_cnt6_pc0", issue_pc[31:0], 32'h2008);
        do_flush();

        // Steady-state enqueue/dequeue across pointer wrap
        beat(32'h3000);
        cyc();
        for (int j = 1; j <= 20; j++) begin
            beat(32'h3000 + 32'(8*j));
            issue_take = 2;
            cyc();
            chk("t4_valid", 32'(issue_valid), 32'h3);
            chk("t4_pc0", issue_pc[31:0], 32'h3000 + 32'(8*j));
            chk("t4_pc1", issue_pc[63:32], 32'h3004 + 32'(8*j));
            chk("t4_inst0", issue_inst[31:0], 32'h3000 + 32'(8*j));
        end
        fetch_valid = 1'b0;
        cyc();
        chk("t4_drained", 32'(issue_valid), 32'h0);
        issue_take = 0;
        beat(32'h5004);
        cyc();
        fetch_valid = 1'b0;
        chk("t4_one_valid", 32'(issue_valid), 32'h1);
        chk("t4_one_pc", issue_pc[31:0], 32'h5004);
        issue_take = 3;
        cyc();
        issue_take = 0;
        chk("t4_clamp_valid", 32'(issue_valid), 32'h0);
        chk("t4_clamp_ready", 32'(fetch_ready), 32'h1);
        beat(32'h6000);
        cyc();
        fetch_valid = 1'b0;
        chk("t4_after_valid", 32'(issue_valid), 32'h3);
        chk("t4_after_pc0", issue_pc[31:0], 32'h6000);
        do_flush();

        // Flush with a concurrent beat
        beat(32'h7000); cyc();
        beat(32'h7008); cyc();
        beat(32'h7014); cyc();
        chk("t5_model_cnt", 32'(mq.size()), 32'd5);
        beat(32'h8000);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        fetch_valid = 1'b0;
        chk("t5_flush_valid", 32'(issue_valid), 32'h0);
        chk("t5_flush_ready", 32'(fetch_ready), 32'h1);
        cyc();
        chk("t5_flush_dropped", 32'(issue_valid), 32'h0);

        // Reset mid-stream with a concurrent beat
        beat(32'h7000); cyc();
        beat(32'h7008); cyc();
        beat(32'h8000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        fetch_valid = 1'b0;
        chk("t5_rst_valid", 32'(issue_valid), 32'h0);
        chk("t5_rst_ready", 32'(fetch_ready), 32'h1);
        cyc();
        chk("t5_rst_dropped", 32'(issue_valid), 32'h0);

`ifdef IFQ_STATS_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h9000 + 32'(8*i));
            cyc();
        end
        fetch_valid = 1'b0;
        repeat (10) cyc();
        chk("t6_full10", stat_full_cyc, 32'd10);
        chk("t6_empty1", stat_empty_cyc, 32'd1);
        issue_take = 2;
        repeat (4) cyc();
        issue_take = 0;
        repeat (3) cyc();
        chk("t6_full11", stat_full_cyc, 32'd11);
        chk("t6_empty4", stat_empty_cyc, 32'd4);
        beat(32'hA000);
        cyc();
        do_flush();
        chk("t6_flush_full", stat_full_cyc, 32'd11);
        chk("t6_flush_empty", stat_empty_cyc, 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_full", stat_full_cyc, 32'd0);
        chk("t6_rst_empty", stat_empty_cyc, 32'd0);
`endif

        cyc();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
